// File: rtl/serial_tx_negedge_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_negedge_if
// Brief    : Request/payload and serial-line status bundle for serial_tx_negedge.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_tx_negedge_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output data,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data,
        output tx,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/serial_tx_negedge.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_negedge
// Brief    : Falling-edge framed serial transmitter (start, LSB-first data,
//            optional even parity under TX_PARITY_EN, stop).
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_negedge #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  wire logic         clock,
    input  wire logic         resetn,
    serial_tx_negedge_if.slave bus
);
    localparam int c_cnt_w = $clog2(CLKS_PER_BIT) + 1;
    localparam int c_idx_w = $clog2(DATA_W) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nx;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_idx_w-1:0]  w_idx_nx;
    logic [DATA_W-1:0]   r_shreg;
    logic [DATA_W-1:0]   w_shreg_nx;
    logic [DATA_W-1:0]   w_sh_shift;
    logic                r_tx;
    logic                w_tx_nx;
    logic                r_busy;
    logic                w_busy_nx;
    logic                r_done;
    logic                w_done_nx;
    logic                w_bit_end;
`ifdef TX_PARITY_EN
    logic                r_parity;
    logic                w_parity_nx;
`endif

    assign w_bit_end  = (r_cnt == c_cnt_last);
    assign w_sh_shift = r_shreg >> 1;

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

    always_ff @(negedge clock) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shreg  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_idx    <= w_idx_nx;
            r_shreg  <= w_shreg_nx;
            r_tx     <= w_tx_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
`ifdef TX_PARITY_EN
            r_parity <= w_parity_nx;
`endif
        end
    end

    // Output registers are loaded with the value for the state being entered,
    // so tx changes on the same edge as the state transition.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = w_bit_end ? '0 : r_cnt + c_cnt_w'(1);
        w_idx_nx    = r_idx;
        w_shreg_nx  = r_shreg;
        w_tx_nx     = 1'b1;
        w_busy_nx   = 1'b1;
        w_done_nx   = 1'b0;
`ifdef TX_PARITY_EN
        w_parity_nx = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_busy_nx = 1'b0;
                w_cnt_nx  = '0;
                if (bus.start) begin
                    w_state_nx  = S_START;
                    w_idx_nx    = '0;
                    w_shreg_nx  = bus.data;
                    w_tx_nx     = 1'b0;
                    w_busy_nx   = 1'b1;
`ifdef TX_PARITY_EN
                    w_parity_nx = ^bus.data;
`endif
                end
            end
            S_START: begin
                w_tx_nx = 1'b0;
                if (w_bit_end) begin
                    w_state_nx = S_DATA;
                    w_tx_nx    = r_shreg[0];
                end
            end
            S_DATA: begin
                w_tx_nx = r_shreg[0];
                if (w_bit_end) begin
                    if (r_idx == c_idx_last) begin
`ifdef TX_PARITY_EN
                        w_state_nx = S_PARITY;
                        w_tx_nx    = r_parity;
`else
                        w_state_nx = S_STOP;
                        w_tx_nx    = 1'b1;
`endif
                    end else begin
                        w_idx_nx   = r_idx + c_idx_w'(1);
                        w_shreg_nx = w_sh_shift;
                        w_tx_nx    = w_sh_shift[0];
                    end
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                w_tx_nx = r_parity;
                if (w_bit_end) begin
                    w_state_nx = S_STOP;
                    w_tx_nx    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nx = S_IDLE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
                w_cnt_nx   = '0;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_serial_tx_negedge.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx_negedge
// Brief    : Self-checking bench for serial_tx_negedge against a slot-based
//            frame model (honours TX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx_negedge;
    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef TX_PARITY_EN
    localparam int FL  = (W + 3) * CPB;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = (W + 2) * CPB;
    localparam bit PAR = 1'b0;
`endif

    logic clock;
    logic resetn;

    serial_tx_negedge_if #(.DATA_W(W)) bus ();

    serial_tx_negedge #(
        .DATA_W       (W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a frame is a list of bit slots, each CPB cycles long.
    bit           m_act = 1'b0;
    int           m_off = 0;
    logic [W-1:0] m_data = '0;

    int tick_n = 0;
    int acc_tick = 0;
    int done_tick = 0;
    int prev_done_tick = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at tick %0d", tag, got, exp, tick_n);
        end
    endtask

    function automatic logic exp_tx();
        int slot;
        if (!m_act || m_off >= FL) return 1'b1;
        slot = m_off / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= W) return m_data[slot-1];
        if (PAR && slot == W + 1) return ^m_data;
        return 1'b1;
    endfunction

    task automatic tick(input logic rn, input logic st, input logic [W-1:0] d);
        resetn    = rn;
        bus.start = st;
        bus.data  = d;
        @(negedge clock);
        tick_n++;
        if (!rn) begin
            m_act = 1'b0;
        end else if (!m_act || m_off >= FL) begin
            if (st) begin
                m_act    = 1'b1;
                m_off    = 0;
                m_data   = d;
                acc_tick = tick_n;
            end else begin
                m_act = 1'b0;
            end
        end else begin
            m_off++;
        end
        @(posedge clock);
        chk("tx",   {31'd0, bus.tx},   {31'd0, exp_tx()});
        chk("busy", {31'd0, bus.busy}, {31'd0, (m_act && m_off < FL)});
        chk("done", {31'd0, bus.done}, {31'd0, (m_act && m_off == FL)});
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
            prev_done_tick = done_tick;
            done_tick      = tick_n;
            done_cnt++;
        end
    endtask

    initial begin
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.data  = '0;

        repeat (3) tick(1'b0, 1'b1, 8'hFF);

        busy_cnt = 0; done_cnt = 0;
        tick(1'b1, 1'b1, 8'hA5);
        repeat (FL + 4) tick(1'b1, 1'b0, 8'hA5);
        chk("a5_busy_len", busy_cnt, FL);
        chk("a5_done_cnt", done_cnt, 1);
        chk("a5_done_lat", done_tick - acc_tick, FL);

        done_cnt = 0;
        tick(1'b1, 1'b1, 8'h00);
        for (int i = 1; i < FL + 4; i++)
            tick(1'b1, (i == 12), (i == 12) ? 8'hFF : 8'h00);
        chk("ign_done_cnt", done_cnt, 1);

        done_cnt = 0;
        repeat (3 * (FL + 1) + 2) tick(1'b1, 1'b1, 8'h3C);
        chk("b2b_done_cnt", done_cnt, 3);
        chk("b2b_period", done_tick - prev_done_tick, FL + 1);
        repeat (FL + 2) tick(1'b1, 1'b0, 8'h00);

        done_cnt = 0;
        tick(1'b1, 1'b1, 8'h5A);
        repeat (16) tick(1'b1, 1'b0, 8'h5A);
        repeat (2) tick(1'b0, 1'b0, 8'h00);
        repeat (FL) tick(1'b1, 1'b0, 8'h00);
        chk("rst_mid_done_cnt", done_cnt, 0);
        tick(1'b1, 1'b1, 8'hC3);
        repeat (FL + 2) tick(1'b1, 1'b0, 8'h00);
        chk("rst_new_done_cnt", done_cnt, 1);

        tick(1'b1, 1'b1, 8'h07);
        repeat (FL + 2) tick(1'b1, 1'b0, 8'h00);
        chk("len_07", done_tick - acc_tick, FL);
        tick(1'b1, 1'b1, 8'h03);
        repeat (FL + 2) tick(1'b1, 1'b0, 8'h00);
        chk("len_03", done_tick - acc_tick, FL);

        repeat (3000)
            tick(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) == 0), W'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
